// File: rtl/player_motion_pkg.sv
// Shared game definitions: screen geometry, coordinate types and the game state
// enum reused by the game-control FSM.
package player_motion_pkg;

    localparam int H_VIS   = 640;
    localparam int V_VIS   = 480;
    localparam int COORD_W = 10;

    typedef logic        [COORD_W-1:0] coord_t;
    typedef logic signed [COORD_W:0]   scoord_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        FROZEN = 2'd2
    } game_state_e;

    // Opposite edge of a square sprite whose near edge is at `near_edge`.
    function automatic coord_t far_edge(input coord_t near_edge, input int size);
        far_edge = near_edge + coord_t'(size - 1);
    endfunction

endpackage

// File: rtl/player_motion_axis_step.sv
// One axis of sprite motion: applies +/-STEP from a button pair and clamps the
// result onto [LO, HI] so the limit value itself is always reached.
module player_motion_axis_step
    import player_motion_pkg::*;
#(
    parameter int STEP = 2,
    parameter int LO   = 0,
    parameter int HI   = 624
) (
    input  coord_t coord,
    input  logic   dec,
    input  logic   inc,
    output coord_t coord_next,
    output logic   changed
);

    localparam scoord_t STEP_S = scoord_t'(STEP);
    localparam scoord_t LO_S   = scoord_t'(LO);
    localparam scoord_t HI_S   = scoord_t'(HI);

    scoord_t cur_s;
    scoord_t cand_s;

    // Signed candidate position, then clamp so underflow below zero is caught.
    always_comb begin
        cur_s  = scoord_t'({1'b0, coord});
        cand_s = cur_s;
        if (inc && !dec) begin
            cand_s = cur_s + STEP_S;
        end else if (dec && !inc) begin
            cand_s = cur_s - STEP_S;
        end else begin
            cand_s = cur_s;
        end

        if (cand_s < LO_S) begin
            coord_next = LO_S[COORD_W-1:0];
        end else if (cand_s > HI_S) begin
            coord_next = HI_S[COORD_W-1:0];
        end else begin
            coord_next = cand_s[COORD_W-1:0];
        end

        changed = (coord_next != coord);
    end

endmodule

// File: rtl/player_motion.sv
// Player sprite position owner: frame-paced button motion clamped to the arena,
// frozen on a hit from the hit detector until restart.
module player_motion
    import player_motion_pkg::*;
#(
    parameter int SIZE      = 16,
    parameter int START_X   = 312,
    parameter int START_Y   = 232,
    parameter int STEP      = 2,
    parameter int FRAME_DIV = 2,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = H_VIS - 1,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = V_VIS - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               run,
    input  logic               hit,
    input  logic               restart,
    output logic [COORD_W-1:0] play_top,
    output logic [COORD_W-1:0] play_bottom,
    output logic [COORD_W-1:0] play_left,
    output logic [COORD_W-1:0] play_right,
    output logic               moving,
    output logic               frozen
);

    localparam coord_t     START_X_C = coord_t'(START_X);
    localparam coord_t     START_Y_C = coord_t'(START_Y);
    localparam logic [3:0] DIV_LAST  = 4'(FRAME_DIV - 1);

    coord_t      x_q, x_d;
    coord_t      y_q, y_d;
    logic [3:0]  div_cnt_q, div_cnt_d;
    game_state_e state_q, state_d;
    logic        moving_q, moving_d;
    logic        frozen_q, frozen_d;

    coord_t      x_next;
    coord_t      y_next;
    logic        x_chg;
    logic        y_chg;

    player_motion_axis_step #(
        .STEP (STEP),
        .LO   (X_MIN),
        .HI   (X_MAX - SIZE + 1)
    ) u_x_step (
        .coord      (x_q),
        .dec        (btn_left),
        .inc        (btn_right),
        .coord_next (x_next),
        .changed    (x_chg)
    );

    player_motion_axis_step #(
        .STEP (STEP),
        .LO   (Y_MIN),
        .HI   (Y_MAX - SIZE + 1)
    ) u_y_step (
        .coord      (y_q),
        .dec        (btn_up),
        .inc        (btn_down),
        .coord_next (y_next),
        .changed    (y_chg)
    );

    // Next-state logic: restart beats hit, hit beats any motion due this cycle.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        div_cnt_d = div_cnt_q;
        state_d   = state_q;
        moving_d  = 1'b0;

        if (restart) begin
            x_d       = START_X_C;
            y_d       = START_Y_C;
            div_cnt_d = 4'd0;
            state_d   = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    div_cnt_d = 4'd0;
                    if (run) begin
                        state_d = MOVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                MOVE: begin
                    if (hit) begin
                        state_d   = FROZEN;
                        div_cnt_d = 4'd0;
                    end else if (!run) begin
                        state_d   = IDLE;
                        div_cnt_d = 4'd0;
                    end else if (frame_tick) begin
                        if (div_cnt_q == DIV_LAST) begin
                            div_cnt_d = 4'd0;
                            x_d       = x_next;
                            y_d       = y_next;
                            moving_d  = x_chg | y_chg;
                        end else begin
                            div_cnt_d = div_cnt_q + 4'd1;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q;
                    end
                end
                FROZEN: begin
                    div_cnt_d = 4'd0;
                end
                default: begin
                    state_d   = IDLE;
                    div_cnt_d = 4'd0;
                end
            endcase
        end

        frozen_d = (state_d == FROZEN);
    end

    // State and position registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q       <= START_X_C;
            y_q       <= START_Y_C;
            div_cnt_q <= 4'd0;
            state_q   <= IDLE;
            moving_q  <= 1'b0;
            frozen_q  <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            div_cnt_q <= div_cnt_d;
            state_q   <= state_d;
            moving_q  <= moving_d;
            frozen_q  <= frozen_d;
        end
    end

    // Edges depend on the position registers only, so no path from hit back to them.
    assign play_top    = y_q;
    assign play_bottom = far_edge(y_q, SIZE);
    assign play_left   = x_q;
    assign play_right  = far_edge(x_q, SIZE);
    assign moving      = moving_q;
    assign frozen      = frozen_q;

endmodule
